// File: rtl/alu_pkg.sv
// Shared constants and types for the sequential co-processor ALU.
package alu_pkg;

    localparam int unsigned DEF_WIDTH = 8;

    localparam logic [7:0] DEF_OP_ADD = 8'h2B;
    localparam logic [7:0] DEF_OP_SUB = 8'h02;
    localparam logic [7:0] DEF_OP_MUL = 8'h03;
    localparam logic [7:0] DEF_OP_DIV = 8'h04;

    // Bit positions inside o_err
    localparam int unsigned ERR_DIV0    = 0;
    localparam int unsigned ERR_ILLEGAL = 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2
    } state_e;

endpackage

// File: rtl/alu_seq_if.sv
// Command/result bundle between the command decoder and the ALU.
interface alu_seq_if #(
    parameter int unsigned WIDTH = 8
) ();

    logic             i_ready;
    logic [WIDTH-1:0] i_num_1;
    logic [WIDTH-1:0] i_num_2;
    logic [7:0]       op_code;
    logic [WIDTH-1:0] result_Hi;
    logic [WIDTH-1:0] result_Lo;
    logic             o_ready;
    logic             o_busy;
    logic [1:0]       o_err;

    // Command issuer side
    modport master (
        output i_ready, i_num_1, i_num_2, op_code,
        input  result_Hi, result_Lo, o_ready, o_busy, o_err
    );

    // ALU side
    modport slave (
        input  i_ready, i_num_1, i_num_2, op_code,
        output result_Hi, result_Lo, o_ready, o_busy, o_err
    );

endinterface

// File: rtl/alu_seq_divider.sv
// Iterative restoring divider: one quotient bit per clock, WIDTH clocks per divide.
// quotient/remainder present the result of the current step, so they are
// valid in the cycle where done is high and can be captured at that edge.
module alu_seq_divider #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             done
);

    localparam int unsigned CW = $clog2(WIDTH + 1);

    logic             busy_q, busy_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;

    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   trial;
    logic             fits;
    logic [WIDTH-1:0] quo_step;
    logic [WIDTH-1:0] rem_step;

    // One restoring step plus load/iterate control
    always_comb begin
        shifted  = {rem_q, quo_q[WIDTH-1]};
        trial    = shifted - {1'b0, dvs_q};
        fits     = ~trial[WIDTH];
        quo_step = {quo_q[WIDTH-2:0], fits};
        rem_step = fits ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];

        busy_d = busy_q;
        cnt_d  = cnt_q;
        quo_d  = quo_q;
        rem_d  = rem_q;
        dvs_d  = dvs_q;

        if (start) begin
            busy_d = 1'b1;
            cnt_d  = CW'(WIDTH);
            quo_d  = dividend;
            rem_d  = '0;
            dvs_d  = divisor;
        end else if (busy_q) begin
            quo_d = quo_step;
            rem_d = rem_step;
            cnt_d = cnt_q - CW'(1);
            if (cnt_q == CW'(1)) begin
                busy_d = 1'b0;
            end
        end
    end

    // Divider state registers
    always_ff @(posedge clk) begin
        if (!reset) begin
            busy_q <= 1'b0;
            cnt_q  <= '0;
            quo_q  <= '0;
            rem_q  <= '0;
            dvs_q  <= '0;
        end else begin
            busy_q <= busy_d;
            cnt_q  <= cnt_d;
            quo_q  <= quo_d;
            rem_q  <= rem_d;
            dvs_q  <= dvs_d;
        end
    end

    assign quotient  = quo_step;
    assign remainder = rem_step;
    assign done      = busy_q && (cnt_q == CW'(1));

endmodule

// File: rtl/alu_seq.sv
// Multi-cycle co-processor ALU: single-cycle add/sub, iterative multiply
// and restoring divide, with busy/ready handshake and error flags.
module alu_seq
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH  = DEF_WIDTH,
    parameter logic [7:0]  OP_ADD = DEF_OP_ADD,
    parameter logic [7:0]  OP_SUB = DEF_OP_SUB,
    parameter logic [7:0]  OP_MUL = DEF_OP_MUL,
    parameter logic [7:0]  OP_DIV = DEF_OP_DIV
) (
    input logic       clk,
    input logic       reset,
    alu_seq_if.slave  bus
);

    localparam int unsigned CW = $clog2(WIDTH + 1);

    state_e             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [2*WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               ready_q, ready_d;
    logic               busy_q, busy_d;
    logic [1:0]         err_q, err_d;

    logic [WIDTH:0]     sum;
    logic [WIDTH:0]     diff;
    logic [2*WIDTH-1:0] acc_step;

    logic               div_start;
    logic [WIDTH-1:0]   div_quo;
    logic [WIDTH-1:0]   div_rem;
    logic               div_done;

    alu_seq_divider #(
        .WIDTH (WIDTH)
    ) u_divider (
        .clk       (clk),
        .reset     (reset),
        .start     (div_start),
        .dividend  (bus.i_num_1),
        .divisor   (bus.i_num_2),
        .quotient  (div_quo),
        .remainder (div_rem),
        .done      (div_done)
    );

    // Command decode, multiplier step and result selection
    always_comb begin
        sum      = {1'b0, bus.i_num_1} + {1'b0, bus.i_num_2};
        diff     = {1'b0, bus.i_num_1} - {1'b0, bus.i_num_2};
        acc_step = mplier_q[0] ? (acc_q + mcand_q) : acc_q;

        state_d   = state_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        mcand_d   = mcand_q;
        mplier_d  = mplier_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        err_d     = err_q;
        ready_d   = 1'b0;
        div_start = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (bus.i_ready) begin
                    if (bus.op_code == OP_ADD) begin
                        hi_d    = sum[WIDTH-1:0];
                        lo_d    = {{(WIDTH-1){1'b0}}, sum[WIDTH]};
                        err_d   = '0;
                        ready_d = 1'b1;
                    end else if (bus.op_code == OP_SUB) begin
                        // borrow out of the extended subtract equals (A < B)
                        hi_d    = diff[WIDTH-1:0];
                        lo_d    = {{(WIDTH-1){1'b0}}, diff[WIDTH]};
                        err_d   = '0;
                        ready_d = 1'b1;
                    end else if (bus.op_code == OP_MUL) begin
                        state_d  = ST_MUL;
                        cnt_d    = CW'(WIDTH);
                        acc_d    = '0;
                        mcand_d  = {{WIDTH{1'b0}}, bus.i_num_1};
                        mplier_d = bus.i_num_2;
                    end else if (bus.op_code == OP_DIV) begin
                        if (bus.i_num_2 == '0) begin
                            hi_d             = '1;
                            lo_d             = bus.i_num_1;
                            err_d            = '0;
                            err_d[ERR_DIV0]  = 1'b1;
                            ready_d          = 1'b1;
                        end else begin
                            state_d   = ST_DIV;
                            div_start = 1'b1;
                        end
                    end else begin
                        hi_d               = '0;
                        lo_d               = '0;
                        err_d              = '0;
                        err_d[ERR_ILLEGAL] = 1'b1;
                        ready_d            = 1'b1;
                    end
                end
            end

            ST_MUL: begin
                acc_d    = acc_step;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    hi_d    = acc_step[2*WIDTH-1:WIDTH];
                    lo_d    = acc_step[WIDTH-1:0];
                    err_d   = '0;
                    ready_d = 1'b1;
                    state_d = ST_IDLE;
                end
            end

            ST_DIV: begin
                if (div_done) begin
                    hi_d    = div_quo;
                    lo_d    = div_rem;
                    err_d   = '0;
                    ready_d = 1'b1;
                    state_d = ST_IDLE;
                end
            end

            default: state_d = ST_IDLE;
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    // State, datapath and output registers
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            err_q    <= '0;
            ready_q  <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            err_q    <= err_d;
            ready_q  <= ready_d;
            busy_q   <= busy_d;
        end
    end

    assign bus.result_Hi = hi_q;
    assign bus.result_Lo = lo_q;
    assign bus.o_ready   = ready_q;
    assign bus.o_busy    = busy_q;
    assign bus.o_err     = err_q;

endmodule

// File: tb/tb_alu_seq.sv
// Directed self-checking bench for alu_seq (WIDTH=8).
module tb_alu_seq;

    localparam int unsigned W = 8;

    logic clk = 1'b0;
    logic reset = 1'b0;

    always #5 clk = ~clk;

    alu_seq_if #(.WIDTH(W)) bus ();

    alu_seq #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge after the acceptance edge
    task automatic issue(input logic [7:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        bus.i_ready = 1'b1;
        bus.op_code = op;
        bus.i_num_1 = a;
        bus.i_num_2 = b;
        @(posedge clk);
        @(negedge clk);
        bus.i_ready = 1'b0;
    endtask

    task automatic check_res(input string tag, input logic [W-1:0] hi, input logic [W-1:0] lo,
                             input logic [1:0] err);
        check({tag, "_hi"},  32'(bus.result_Hi), 32'(hi));
        check({tag, "_lo"},  32'(bus.result_Lo), 32'(lo));
        check({tag, "_err"}, 32'(bus.o_err),     32'(err));
    endtask

    // Counts cycles from the negedge after N until o_ready, bounded
    task automatic wait_ready(input string tag, input int exp_lat);
        int n;
        n = 0;
        while (bus.o_ready !== 1'b1 && n < 40) begin
            @(posedge clk);
            @(negedge clk);
            n++;
        end
        check({tag, "_lat"}, 32'(n), 32'(exp_lat));
    endtask

    initial begin
        bus.i_ready = 1'b0;
        bus.op_code = '0;
        bus.i_num_1 = '0;
        bus.i_num_2 = '0;
        reset = 1'b0;
        repeat (2) @(negedge clk);

        check("rst_hi",    32'(bus.result_Hi), 32'h0);
        check("rst_lo",    32'(bus.result_Lo), 32'h0);
        check("rst_ready", 32'(bus.o_ready),   32'h0);
        check("rst_busy",  32'(bus.o_busy),    32'h0);
        check("rst_err",   32'(bus.o_err),     32'h0);
        reset = 1'b1;
        @(negedge clk);

        // ADD with carry
        issue(8'h2B, 8'd200, 8'd100);
        check_res("add", 8'h2C, 8'h01, 2'b00);
        check("add_ready", 32'(bus.o_ready), 32'h1);
        check("add_busy",  32'(bus.o_busy),  32'h0);
        @(negedge clk);
        check("add_ready_off", 32'(bus.o_ready),   32'h0);
        check("add_hold_hi",   32'(bus.result_Hi), 32'h2C);

        // SUB with borrow, then ADD back-to-back
        issue(8'h02, 8'd5, 8'd7);
        check_res("sub", 8'hFE, 8'h01, 2'b00);
        check("sub_ready", 32'(bus.o_ready), 32'h1);
        issue(8'h2B, 8'd1, 8'd1);
        check_res("add2", 8'h02, 8'h00, 2'b00);
        check("add2_ready", 32'(bus.o_ready), 32'h1);
        @(negedge clk);
        check("add2_ready_off", 32'(bus.o_ready), 32'h0);

        // SUB without borrow
        issue(8'h02, 8'd7, 8'd5);
        check_res("sub2", 8'h02, 8'h00, 2'b00);
        @(negedge clk);

        // MUL 255*255 with an ignored ADD at N+3
        issue(8'h03, 8'd255, 8'd255);
        check("mul_busy_n",  32'(bus.o_busy),  32'h1);
        check("mul_ready_n", 32'(bus.o_ready), 32'h0);
        for (int k = 1; k <= 7; k++) begin
            @(posedge clk);
            @(negedge clk);
            check("mul_busy",  32'(bus.o_busy),  32'h1);
            check("mul_ready", 32'(bus.o_ready), 32'h0);
            if (k == 2) begin
                bus.i_ready = 1'b1;
                bus.op_code = 8'h2B;
                bus.i_num_1 = 8'd1;
                bus.i_num_2 = 8'd1;
            end
            if (k == 3) bus.i_ready = 1'b0;
        end
        @(posedge clk);
        @(negedge clk);
        check("mul_ready_done", 32'(bus.o_ready), 32'h1);
        check("mul_busy_done",  32'(bus.o_busy),  32'h0);
        check_res("mul", 8'hFE, 8'h01, 2'b00);
        @(negedge clk);
        check("mul_no_extra", 32'(bus.o_ready),   32'h0);
        check("mul_hold_hi",  32'(bus.result_Hi), 32'hFE);

        // DIV 200/7
        issue(8'h04, 8'd200, 8'd7);
        check("div_busy_n", 32'(bus.o_busy), 32'h1);
        wait_ready("div", 8);
        check_res("div", 8'h1C, 8'h04, 2'b00);
        @(negedge clk);

        // DIV where divisor exceeds dividend
        issue(8'h04, 8'd7, 8'd200);
        wait_ready("div_small", 8);
        check_res("div_small", 8'h00, 8'h07, 2'b00);
        @(negedge clk);

        // DIV by zero
        issue(8'h04, 8'd13, 8'd0);
        check_res("div0", 8'hFF, 8'h0D, 2'b01);
        check("div0_ready", 32'(bus.o_ready), 32'h1);
        check("div0_busy",  32'(bus.o_busy),  32'h0);
        @(negedge clk);
        check("div0_busy_after", 32'(bus.o_busy), 32'h0);

        // Illegal opcode
        issue(8'h55, 8'd9, 8'd9);
        check_res("ill", 8'h00, 8'h00, 2'b10);
        check("ill_ready", 32'(bus.o_ready), 32'h1);
        @(negedge clk);

        // Reset in the middle of a MUL
        issue(8'h03, 8'd15, 8'd15);
        repeat (3) begin
            @(posedge clk);
            @(negedge clk);
        end
        reset = 1'b0;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        check("mrst_hi",    32'(bus.result_Hi), 32'h0);
        check("mrst_lo",    32'(bus.result_Lo), 32'h0);
        check("mrst_err",   32'(bus.o_err),     32'h0);
        check("mrst_ready", 32'(bus.o_ready),   32'h0);
        check("mrst_busy",  32'(bus.o_busy),    32'h0);
        for (int k = 5; k <= 12; k++) begin
            @(posedge clk);
            @(negedge clk);
            check("mrst_noready", 32'(bus.o_ready), 32'h0);
            check("mrst_idle",    32'(bus.o_busy),  32'h0);
        end
        issue(8'h03, 8'd15, 8'd15);
        wait_ready("mul2", 8);
        check_res("mul2", 8'h00, 8'hE1, 2'b00);
        @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
